// File: rtl/cw_input.sv
// Clockwise-ring input port: one single-flit buffer per virtual channel (even/odd),
// routing each buffered flit onward (CW) or to the local PE from the LSB of its hop field.
module cw_input #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  cwsi,
  input  logic [DATA_WIDTH-1:0] cwdi,
  output logic                  cwri,
  output logic [DATA_WIDTH-1:0] data_out_even,
  output logic [DATA_WIDTH-1:0] data_out_odd,
  output logic                  request_cw_even,
  output logic                  request_cw_odd,
  output logic                  request_pe_even,
  output logic                  request_pe_odd,
  input  logic                  grant_cw_even,
  input  logic                  grant_cw_odd,
  input  logic                  grant_pe_even,
  input  logic                  grant_pe_odd,
  output logic                  ovf
);

  localparam int VcBit  = DATA_WIDTH - 1;
  localparam int HopLsb = 48;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } vcState_t;

  vcState_t              r_stateEven, r_stateOdd;
  vcState_t              w_nextEven, w_nextOdd;
  logic [DATA_WIDTH-1:0] r_bufEven, r_bufOdd;
  logic                  r_ovf;

  logic w_fullEven, w_fullOdd;
  logic w_wrEven, w_wrOdd;
  logic w_relEven, w_relOdd;

  assign w_fullEven = (r_stateEven == FULL);
  assign w_fullOdd  = (r_stateOdd == FULL);
  assign w_wrEven   = cwsi & ~cwdi[VcBit];
  assign w_wrOdd    = cwsi & cwdi[VcBit];

  // Hop LSB set means hops remain, so forward; clear means we are the destination.
  assign request_cw_even = w_fullEven & r_bufEven[HopLsb];
  assign request_pe_even = w_fullEven & ~r_bufEven[HopLsb];
  assign request_cw_odd  = w_fullOdd & r_bufOdd[HopLsb];
  assign request_pe_odd  = w_fullOdd & ~r_bufOdd[HopLsb];

  assign w_relEven = (request_cw_even & grant_cw_even) | (request_pe_even & grant_pe_even);
  assign w_relOdd  = (request_cw_odd & grant_cw_odd) | (request_pe_odd & grant_pe_odd);

  assign cwri          = polarity ? ~w_fullOdd : ~w_fullEven;
  assign data_out_even = r_bufEven;
  assign data_out_odd  = r_bufOdd;
  assign ovf           = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stateEven <= EMPTY;
      r_stateOdd  <= EMPTY;
    end else begin
      r_stateEven <= w_nextEven;
      r_stateOdd  <= w_nextOdd;
    end
  end

  // A write arriving while FULL is dropped even if the same edge releases the buffer.
  always_comb begin
    w_nextEven = r_stateEven;
    w_nextOdd  = r_stateOdd;
    case (r_stateEven)
      EMPTY:   if (w_wrEven) w_nextEven = FULL;
      FULL:    if (w_relEven) w_nextEven = EMPTY;
      default: w_nextEven = EMPTY;
    endcase
    case (r_stateOdd)
      EMPTY:   if (w_wrOdd) w_nextOdd = FULL;
      FULL:    if (w_relOdd) w_nextOdd = EMPTY;
      default: w_nextOdd = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bufEven <= '0;
      r_bufOdd  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (!w_fullEven && w_wrEven) r_bufEven <= cwdi;
      if (!w_fullOdd && w_wrOdd)   r_bufOdd  <= cwdi;
      r_ovf <= (w_fullEven & w_wrEven) | (w_fullOdd & w_wrOdd);
    end
  end

endmodule

// File: tb/tb_cw_input.sv
// Scoreboard bench for cw_input: each directed step queues the outputs expected
// after its clock edge; a negedge monitor pops and compares them.
module tb_cw_input;

  logic        clk = 1'b0;
  logic        rst;
  logic        polarity;
  logic        cwsi;
  logic [63:0] cwdi;
  logic        cwri;
  logic [63:0] data_out_even, data_out_odd;
  logic        request_cw_even, request_cw_odd, request_pe_even, request_pe_odd;
  logic        grant_cw_even, grant_cw_odd, grant_pe_even, grant_pe_odd;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [5:0]  ctrl;
    logic [63:0] dataE;
    logic [63:0] dataO;
  } expect_t;

  expect_t scoreQ[$];

  localparam logic [63:0] FwdFlit  = 64'h0003_0000_0000_00AA;
  localparam logic [63:0] OvfFlit  = 64'h0001_0000_0000_0BAD;
  localparam logic [63:0] EjFlit   = 64'h8000_0000_0000_0055;
  localparam logic [63:0] OddPe    = 64'h8002_0000_0000_0077;
  localparam logic [63:0] OddCw    = 64'h8001_0000_0000_0099;

  cw_input #(.DATA_WIDTH(64)) dut (
    .clk(clk),
    .rst(rst),
    .polarity(polarity),
    .cwsi(cwsi),
    .cwdi(cwdi),
    .cwri(cwri),
    .data_out_even(data_out_even),
    .data_out_odd(data_out_odd),
    .request_cw_even(request_cw_even),
    .request_cw_odd(request_cw_odd),
    .request_pe_even(request_pe_even),
    .request_pe_odd(request_pe_odd),
    .grant_cw_even(grant_cw_even),
    .grant_cw_odd(grant_cw_odd),
    .grant_pe_even(grant_pe_even),
    .grant_pe_odd(grant_pe_odd),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after a negedge and queue what must be seen
  // at the following negedge. grants = {cw_even, pe_even, cw_odd, pe_odd};
  // expCtrl = {cwri, req_cw_even, req_pe_even, req_cw_odd, req_pe_odd, ovf}.
  task automatic applyStimulus(input string name, input logic rstV, input logic polV,
                               input logic sendV, input logic [63:0] dataV,
                               input logic [3:0] grants, input logic [5:0] expCtrl,
                               input logic [63:0] expE, input logic [63:0] expO);
    expect_t e;
    @(negedge clk);
    #1;
    rst           = rstV;
    polarity      = polV;
    cwsi          = sendV;
    cwdi          = dataV;
    grant_cw_even = grants[3];
    grant_pe_even = grants[2];
    grant_cw_odd  = grants[1];
    grant_pe_odd  = grants[0];
    e.name  = name;
    e.ctrl  = expCtrl;
    e.dataE = expE;
    e.dataO = expO;
    scoreQ.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    logic [5:0] got;
    got = {cwri, request_cw_even, request_pe_even, request_cw_odd, request_pe_odd, ovf};
    checks++;
    if (got !== e.ctrl) begin
      errors++;
      $display("[TB] FAIL %s ctrl {cwri,rce,rpe,rco,rpo,ovf}: got %b expected %b", e.name, got, e.ctrl);
    end
    checks++;
    if (data_out_even !== e.dataE) begin
      errors++;
      $display("[TB] FAIL %s data_out_even: got %h expected %h", e.name, data_out_even, e.dataE);
    end
    checks++;
    if (data_out_odd !== e.dataO) begin
      errors++;
      $display("[TB] FAIL %s data_out_odd: got %h expected %h", e.name, data_out_odd, e.dataO);
    end
  endtask

  // Monitor: compare whenever an expectation is pending.
  always @(negedge clk) begin
    if (scoreQ.size() > 0) checkOutput(scoreQ.pop_front());
  end

  initial begin
    rst = 1'b1; polarity = 1'b0; cwsi = 1'b0; cwdi = '0;
    grant_cw_even = 1'b0; grant_pe_even = 1'b0; grant_cw_odd = 1'b0; grant_pe_odd = 1'b0;

    applyStimulus("rst_send",   1, 0, 1, 64'h0,  4'b0000, 6'b100000, 64'h0,   64'h0);
    applyStimulus("rst_hold",   1, 0, 1, 64'h0,  4'b0000, 6'b100000, 64'h0,   64'h0);

    applyStimulus("fwd_cap",    0, 0, 1, FwdFlit, 4'b0000, 6'b010000, FwdFlit, 64'h0);
    applyStimulus("fwd_wait",   0, 0, 0, 64'h0,  4'b0000, 6'b010000, FwdFlit, 64'h0);
    applyStimulus("fwd_grant",  0, 0, 0, 64'h0,  4'b1000, 6'b100000, FwdFlit, 64'h0);
    applyStimulus("fwd_idle",   0, 0, 0, 64'h0,  4'b0000, 6'b100000, FwdFlit, 64'h0);

    applyStimulus("ej_cap",     0, 1, 1, EjFlit, 4'b0000, 6'b000010, FwdFlit, EjFlit);
    applyStimulus("ej_grant1",  0, 1, 0, 64'h0,  4'b0001, 6'b100000, FwdFlit, EjFlit);
    applyStimulus("ej_grant2",  0, 1, 0, 64'h0,  4'b0001, 6'b100000, FwdFlit, EjFlit);

    applyStimulus("ovf_cap",    0, 0, 1, FwdFlit, 4'b0000, 6'b010000, FwdFlit, EjFlit);
    applyStimulus("ovf_drop",   0, 0, 1, OvfFlit, 4'b0000, 6'b010001, FwdFlit, EjFlit);
    applyStimulus("ovf_clear",  0, 0, 0, 64'h0,  4'b0000, 6'b010000, FwdFlit, EjFlit);

    applyStimulus("ind_both",   0, 0, 1, EjFlit, 4'b1000, 6'b100010, FwdFlit, EjFlit);
    applyStimulus("ind_pol1",   0, 1, 0, 64'h0,  4'b0000, 6'b000010, FwdFlit, EjFlit);
    applyStimulus("ind_rel",    0, 1, 0, 64'h0,  4'b0001, 6'b100000, FwdFlit, EjFlit);

    applyStimulus("wg_cap",     0, 0, 1, FwdFlit, 4'b0000, 6'b010000, FwdFlit, EjFlit);
    applyStimulus("wg_pe",      0, 0, 0, 64'h0,  4'b0100, 6'b010000, FwdFlit, EjFlit);
    applyStimulus("wg_oddcw",   0, 0, 0, 64'h0,  4'b0010, 6'b010000, FwdFlit, EjFlit);
    applyStimulus("wg_both",    0, 0, 0, 64'h0,  4'b1100, 6'b100000, FwdFlit, EjFlit);

    applyStimulus("odd_cap",    0, 1, 1, OddPe,  4'b0000, 6'b000010, FwdFlit, OddPe);
    applyStimulus("odd_droprel",0, 1, 1, OddCw,  4'b0001, 6'b100001, FwdFlit, OddPe);
    applyStimulus("odd_b2b",    0, 1, 1, OddCw,  4'b0000, 6'b000100, FwdFlit, OddCw);
    applyStimulus("odd_ovf",    0, 1, 1, OddCw,  4'b0000, 6'b000101, FwdFlit, OddCw);

    applyStimulus("mid_rst",    1, 1, 0, 64'h0,  4'b0000, 6'b100000, 64'h0,   64'h0);
    applyStimulus("post_rst",   0, 1, 0, 64'h0,  4'b0000, 6'b100000, 64'h0,   64'h0);

    @(negedge clk);
    #1;
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", scoreQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cw_input.md
# cw_input

Clockwise-ring input port of the router. Accepts flits from the upstream router's CW output over the cwsi/cwri/cwdi link and holds them in one single-flit buffer per virtual channel (even, odd). From each flit's hop field it routes the flit either onward to the local CW output or ejects it to the local PE output. It then releases the buffer on the matching grant.

## Interface
Parameters:
- DATA_WIDTH, 64, flit width; field positions below assume 64.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- polarity  in  1  global VC phase: 0 = even phase, 1 = odd phase.
- cwsi  in  1  upstream send strobe; cwdi valid this cycle.
- cwdi  in  DATA_WIDTH  incoming flit.
- cwri  out  1  ready to upstream.
- data_out_even  out  DATA_WIDTH  even-VC buffer contents.
- data_out_odd  out  DATA_WIDTH  odd-VC buffer contents.
- request_cw_even, request_cw_odd  out  1  flit wants the local CW output.
- request_pe_even, request_pe_odd  out  1  flit wants the local PE output.
- grant_cw_even, grant_cw_odd  in  1  CW output has taken the flit.
- grant_pe_even, grant_pe_odd  in  1  PE output has taken the flit.
- ovf  out  1  one-cycle pulse: a flit arrived for a full VC buffer and was dropped.

## Operation
Flit fields:
- [63] VC: 0 = even, 1 = odd.
- [62] direction.
- [61:56] reserved.
- [55:48] hop field, shift-encoded: the upstream output shifts it right by 1 per hop.
- [47:0] source and payload.
- Flits are passed through unmodified.

Per-VC buffer state:
- full_e, full_o: 1 bit each.
- buf_e, buf_o: DATA_WIDTH each.
- Each VC is a 2-state machine: EMPTY, FULL.

Transitions:
- EMPTY -> FULL: cwsi=1 and cwdi[63] selects this VC; buffer captures cwdi at that posedge.
- FULL -> EMPTY: at a posedge where the grant matching the active request is 1.
  - Even VC: request_cw_even & grant_cw_even, or request_pe_even & grant_pe_even. Odd VC likewise.
  - Grants on the non-requested path are ignored.
- FULL and cwsi for the same VC: write dropped, buffer unchanged, ovf=1 next cycle.
- Writes to one VC and grants to the other VC in the same cycle are fully independent.

Routing (combinational from buffer):
- hop = buf[55:48].
- request_cw_x = full_x & (hop[0]==1), i.e. hops remain; forward.
- request_pe_x = full_x & (hop[0]==0), i.e. destination reached; eject.
- At most one of request_cw_x / request_pe_x is high per VC.
- Requests stay high continuously until the buffer clears.

Ready:
- cwri = polarity ? ~full_o : ~full_e.
- cwri is combinational and reflects the VC whose phase is current.

Data:
- data_out_x = buf_x.
- Held stable from capture until the clearing posedge, so downstream may sample on any edge while the grant is high.
- buf_x is not zeroed on release.

## Timing
- Reset values: full_e = full_o = 0; buf_e = buf_o = 0; all request_* = 0; ovf = 0; cwri = 1.
- Reset mid-operation discards buffered flits; requests drop in the cycle after the reset edge.
- Latency: flit captured at posedge N; request high in cycle N+1 (after edge N).
- Release: grant sampled high at posedge M; full = 0 and request = 0 after M; cwri rises for that VC after M.
- Back-to-back throughput: the earliest new capture for the same VC is at posedge M+1, giving 1 flit per VC per 2 cycles minimum.
- A grant held high for more than 1 cycle is harmless: after the clear there is no active request, so the grant is ignored.
- Simultaneous grant_cw_x and grant_pe_x: only the one matching the active request counts.
- ovf is registered: high for exactly 1 cycle per dropped flit.

## Test plan
- Reset: assert rst with cwsi=1, cwdi=64'h0, then hold rst one cycle -> full_e=full_o=0, all requests 0, cwri=1, data_out_even=data_out_odd=0, ovf=0.
- Forward: polarity=0, cwsi=1, cwdi=64'h0003_0000_0000_00AA (hop 8'h03) -> next cycle request_cw_even=1, request_pe_even=0, data_out_even equals cwdi, cwri=0. Pulse grant_cw_even one cycle -> request drops and cwri=1 the following cycle.
- Eject: odd VC, polarity=1, cwdi=64'h8000_0000_0000_0055 (hop 8'h00) -> request_pe_odd=1. Hold grant_pe_odd for 2 cycles -> buffer clears after the first edge, no further effect.
- Overflow: with the even buffer full, send a second even flit 64'h0001_0000_0000_0BAD -> ovf=1 for 1 cycle; data_out_even still holds the first flit.
- Independent VCs: even VC full and waiting; send an odd flit while granting the even VC in the same cycle -> even clears, odd captured, both after the same edge.
- Wrong grant: even flit requesting CW; assert grant_pe_even -> no release. Then assert grant_cw_even -> release.
